// File: rtl/issue_window_sched.sv
// rtl/issue_window_sched.sv - 4-entry in-order issue window with hazard-gated prefix issue
module issue_window_sched #(
  parameter int DES_W   = 4,
  parameter int SRC_W   = 4,
  parameter int PAY_W   = 16,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DES_W-1:0]   in_des,
  input  logic [SRC_W-1:0]   in_s1,
  input  logic [SRC_W-1:0]   in_s2,
  input  logic [PAY_W-1:0]   in_payload,
  output logic [4*DES_W-1:0] chk_des,
  output logic [4*SRC_W-1:0] chk_s1,
  output logic [4*SRC_W-1:0] chk_s2,
  output logic [2:0]         chk_in,
  input  logic [2:0]         chk_ok,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [3:0]         iss_lane,
  output logic [4*PAY_W-1:0] iss_payload,
  output logic [2:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [2:0]         occ_q, occ_d;
  logic [DES_W-1:0]   des_q [4];
  logic [SRC_W-1:0]   s1_q  [4];
  logic [SRC_W-1:0]   s2_q  [4];
  logic [PAY_W-1:0]   pay_q [4];
  logic [DES_W-1:0]   des_d [4];
  logic [SRC_W-1:0]   s1_d  [4];
  logic [SRC_W-1:0]   s2_d  [4];
  logic [PAY_W-1:0]   pay_d [4];
  logic [STALL_W-1:0] stall_q;

  logic       run;
  logic [3:0] slot_v;
  logic [2:0] lane_cnt;
  logic [2:0] n;
  logic [2:0] wpos;
  logic [2:0] idx;
  logic       fire;
  logic       accept;
  logic       stall_inc;

  assign run       = (state_q == RUN);
  assign in_ready  = run && (occ_q < 3'd4);
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;
  assign chk_in    = slot_v[3:1];
  assign iss_valid = |iss_lane;

  always_comb begin
    for (int k = 0; k < 4; k++) slot_v[k] = (occ_q > 3'(k));
  end

  // Lane k issues only if every older lane issues and the checker clears slot k.
  always_comb begin
    iss_lane    = '0;
    iss_lane[0] = run && slot_v[0];
    for (int k = 1; k < 4; k++) iss_lane[k] = iss_lane[k-1] && slot_v[k] && chk_ok[k-1];
    lane_cnt = {2'b0, iss_lane[0]} + {2'b0, iss_lane[1]} + {2'b0, iss_lane[2]} + {2'b0, iss_lane[3]};
  end

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign chk_des[k*DES_W +: DES_W]     = slot_v[k] ? des_q[k] : '0;
    assign chk_s1[k*SRC_W +: SRC_W]      = slot_v[k] ? s1_q[k]  : '0;
    assign chk_s2[k*SRC_W +: SRC_W]      = slot_v[k] ? s2_q[k]  : '0;
    assign iss_payload[k*PAY_W +: PAY_W] = slot_v[k] ? pay_q[k] : '0;
  end

  assign fire      = iss_valid && iss_ready && !flush;
  assign accept    = in_valid && in_ready && !flush;
  assign n         = fire ? lane_cnt : 3'd0;
  assign wpos      = occ_q - n;
  assign stall_inc = run && (occ_q != 3'd0) && (!iss_ready || (lane_cnt < occ_q));

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    idx     = '0;
    for (int k = 0; k < 4; k++) begin
      des_d[k] = des_q[k];
      s1_d[k]  = s1_q[k];
      s2_d[k]  = s2_q[k];
      pay_d[k] = pay_q[k];
    end
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
          occ_d   = 3'd0;
        end else begin
          occ_d = occ_q - n + {2'b0, accept};
          for (int k = 0; k < 4; k++) begin
            idx = 3'(k) + n;
            if (idx < 3'd4) begin
              des_d[k] = des_q[idx[1:0]];
              s1_d[k]  = s1_q[idx[1:0]];
              s2_d[k]  = s2_q[idx[1:0]];
              pay_d[k] = pay_q[idx[1:0]];
            end
            if (accept && (wpos == 3'(k))) begin
              des_d[k] = in_des;
              s1_d[k]  = in_s1;
              s2_d[k]  = in_s2;
              pay_d[k] = in_payload;
            end
          end
        end
      end
      FLUSH: begin
        occ_d = 3'd0;
        if (!flush) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        occ_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      occ_q   <= '0;
      stall_q <= '0;
      for (int k = 0; k < 4; k++) begin
        des_q[k] <= '0;
        s1_q[k]  <= '0;
        s2_q[k]  <= '0;
        pay_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      for (int k = 0; k < 4; k++) begin
        des_q[k] <= des_d[k];
        s1_q[k]  <= s1_d[k];
        s2_q[k]  <= s2_d[k];
        pay_q[k] <= pay_d[k];
      end
    end
  end

endmodule

// File: tb/tb_issue_window_sched.sv
// tb/tb_issue_window_sched.sv - scoreboard bench for issue_window_sched
module tb_issue_window_sched;

  logic        clk, rst_n, flush, in_valid, in_ready, iss_valid, iss_ready;
  logic [3:0]  in_des, in_s1, in_s2, iss_lane;
  logic [15:0] in_payload, chk_des, chk_s1, chk_s2, stall_cnt;
  logic [2:0]  chk_in, chk_ok, occupancy;
  logic [63:0] iss_payload;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  issue_window_sched #(.DES_W(4), .SRC_W(4), .PAY_W(16), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_des(in_des), .in_s1(in_s1), .in_s2(in_s2),
    .in_payload(in_payload), .chk_des(chk_des), .chk_s1(chk_s1), .chk_s2(chk_s2),
    .chk_in(chk_in), .chk_ok(chk_ok), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_lane(iss_lane), .iss_payload(iss_payload), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every lane that fires must carry the oldest outstanding payload.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (rst_n && !flush && iss_valid && iss_ready) begin
      for (int k = 0; k < 4; k++) begin
        if (iss_lane[k]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow lane=%0d got=%h required=none", k, iss_payload[k*16 +: 16]);
          end else begin
            e = exp_q.pop_front();
            if (iss_payload[k*16 +: 16] !== e) begin
              bad++;
              $display("FAIL sb_payload lane=%0d got=%h required=%h", k, iss_payload[k*16 +: 16], e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0; chk_ok = 3'b000;
    in_des = '0; in_s1 = '0; in_s2 = '0; in_payload = '0;
    #3;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                          input logic [15:0] p);
    in_des = d; in_s1 = a; in_s2 = b; in_payload = p; in_valid = 1'b1;
    exp_q.push_back(p);
    step();
    in_valid = 1'b0;
  endtask

  task automatic fill(input int cnt, input logic [15:0] base);
    for (int i = 0; i < cnt; i++) push_one(4'(i + 1), 4'(i + 5), 4'(i + 9), base + 16'(i));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0; chk_ok = 3'b000;
    in_des = '0; in_s1 = '0; in_s2 = '0; in_payload = '0;
    #12;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d required=0", occupancy); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d required=0", stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
    total++; if ({iss_valid, iss_lane} !== 5'b0) begin bad++; $display("FAIL rst_iss got=%b%b required=00000", iss_valid, iss_lane); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_issue();
    do_reset();
    fill(4, 16'h1000);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b required=0", in_ready); end
    chk_ok = 3'b111; iss_ready = 1'b1;
    #1;
    total++; if (iss_lane !== 4'b1111) begin bad++; $display("FAIL full_lane got=%b required=1111", iss_lane); end
    step();
    iss_ready = 1'b0;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_occ got=%0d required=0", occupancy); end
  endtask

  task automatic test_hazard();
    do_reset();
    push_one(4'd1, 4'd2, 4'd3, 16'h2A00);
    push_one(4'd4, 4'd1, 4'd5, 16'h2B00);
    push_one(4'd6, 4'd7, 4'd8, 16'h2C00);
    chk_ok = 3'b010;
    #1;
    total++; if (chk_des !== 16'h0641) begin bad++; $display("FAIL hz_des got=%h required=0641", chk_des); end
    total++; if (chk_s1 !== 16'h0712) begin bad++; $display("FAIL hz_s1 got=%h required=0712", chk_s1); end
    total++; if (chk_s2 !== 16'h0853) begin bad++; $display("FAIL hz_s2 got=%h required=0853", chk_s2); end
    total++; if (chk_in !== 3'b011) begin bad++; $display("FAIL hz_chk_in got=%b required=011", chk_in); end
    total++; if (iss_lane !== 4'b0001) begin bad++; $display("FAIL hz_lane got=%b required=0001", iss_lane); end
    iss_ready = 1'b1;
    step();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL hz_occ got=%0d required=2", occupancy); end
    total++; if (chk_des[3:0] !== 4'd4) begin bad++; $display("FAIL hz_head got=%0d required=4", chk_des[3:0]); end
    chk_ok = 3'b000;
    #1;
    total++; if (iss_lane !== 4'b0001) begin bad++; $display("FAIL hz_lane2 got=%b required=0001", iss_lane); end
    step();
    step();
    iss_ready = 1'b0;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL hz_drain got=%0d required=0", occupancy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill(4, 16'h3000);
    for (int i = 0; i < 5; i++) step();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_occ got=%0d required=4", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b required=0", in_ready); end
    total++; if (stall_cnt !== 16'd8) begin bad++; $display("FAIL bp_stall got=%0d required=8", stall_cnt); end
    chk_ok = 3'b001; iss_ready = 1'b1;
    in_des = 4'hE; in_s1 = 4'h0; in_s2 = 4'h0; in_payload = 16'h3E00; in_valid = 1'b1;
    step();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL bp_occ2 got=%0d required=2", occupancy); end
    exp_q.push_back(16'h3E00);
    chk_ok = 3'b000;
    step();
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL bp_occ3 got=%0d required=2", occupancy); end
    total++; if (chk_des[7:0] !== 8'hE4) begin bad++; $display("FAIL bp_slots got=%h required=e4", chk_des[7:0]); end
    chk_ok = 3'b111;
    step();
    iss_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(3, 16'h4000);
    chk_ok = 3'b001; iss_ready = 1'b1;
    #1;
    total++; if (iss_lane !== 4'b0011) begin bad++; $display("FAIL b2b_lane got=%b required=0011", iss_lane); end
    push_one(4'hD, 4'h0, 4'h0, 16'h4D00);
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_occ got=%0d required=2", occupancy); end
    total++; if (chk_des[7:0] !== 8'hD3) begin bad++; $display("FAIL b2b_slots got=%h required=d3", chk_des[7:0]); end
    total++; if (iss_payload[31:16] !== 16'h4D00) begin bad++; $display("FAIL b2b_pay got=%h required=4d00", iss_payload[31:16]); end
    chk_ok = 3'b111;
    step();
    iss_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    fill(3, 16'h5000);
    chk_ok = 3'b111; iss_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL fl_occ got=%0d required=0", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b required=0", in_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL fl_iss got=%b required=0", iss_valid); end
    iss_ready = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_recover got=%b required=1", in_ready); end
    flush = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_hold got=%b required=0", in_ready); end
    flush = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_release got=%b required=1", in_ready); end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    fill(1, 16'h6000);
    for (int i = 0; i < (1 << 16) + 3; i++) @(posedge clk);
    #1;
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%h required=ffff", stall_cnt); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL sat_occ got=%0d required=1", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL ar_occ got=%0d required=0", occupancy); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL ar_stall got=%h required=0", stall_cnt); end
    total++; if ({in_ready, iss_valid, iss_lane, chk_in} !== 9'b1_0_0000_000) begin
      bad++; $display("FAIL ar_ctrl got=%b%b%b%b required=100000000", in_ready, iss_valid, iss_lane, chk_in);
    end
    total++; if ({chk_des, iss_payload} !== 80'd0) begin bad++; $display("FAIL ar_data got=%h%h required=0", chk_des, iss_payload); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_full_issue();
    test_hazard();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
